// File: rtl/conv_seq_pkg.sv
// Shared widths, FSM state encoding and the per-layer configuration record
// used by the convolution layer sequencer.
package conv_seq_pkg;

  localparam int MAX_LAYERS       = 4;
  localparam int LIDX_WIDTH       = $clog2(MAX_LAYERS);
  localparam int CHANNELNUM_WIDTH = 4;
  localparam int KERNELNUM_WIDTH  = 4;
  localparam int DATANUM_WIDTH    = 5;
  localparam int TIMESTEP_WIDTH   = 8;
  localparam int DRAIN_CYCLES     = 8;
  localparam int DRAIN_CNT_WIDTH  = $clog2(DRAIN_CYCLES + 1);
  localparam int PERF_WIDTH       = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    NEXT,
    FINISH
  } seq_state_t;

  typedef struct packed {
    logic [CHANNELNUM_WIDTH-1:0] outchannel;
    logic [KERNELNUM_WIDTH-1:0]  kernel;
    logic [DATANUM_WIDTH-1:0]    flen;
    logic [TIMESTEP_WIDTH-1:0]   nconv;
  } layer_cfg_t;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Host, table-programming and conv_core signals of the layer sequencer.
// Optional LAYER_PERF_EN adds the last_layer_cycles performance output.
interface conv_layer_sequencer_if;
  import conv_seq_pkg::*;

  logic                        cfg_we;
  logic [LIDX_WIDTH-1:0]       cfg_idx;
  logic [CHANNELNUM_WIDTH-1:0] cfg_outchannel;
  logic [KERNELNUM_WIDTH-1:0]  cfg_kernel;
  logic [DATANUM_WIDTH-1:0]    cfg_flen;
  logic [TIMESTEP_WIDTH-1:0]   cfg_nconv;
  logic [LIDX_WIDTH:0]         num_layers;
  logic                        start;
  logic                        acc;
  logic                        busy;
  logic                        done;
  logic [LIDX_WIDTH-1:0]       layer_idx;
  logic                        core_clear;
  logic                        core_enable;
  logic [CHANNELNUM_WIDTH-1:0] num_outchannel;
  logic [KERNELNUM_WIDTH-1:0]  num_kernel;
  logic [DATANUM_WIDTH-1:0]    filter_length;
  logic [TIMESTEP_WIDTH-1:0]   num_total_conv;
  logic                        err;
`ifdef LAYER_PERF_EN
  logic [PERF_WIDTH-1:0]       last_layer_cycles;
`endif

  modport master (
`ifdef LAYER_PERF_EN
    input  last_layer_cycles,
`endif
    output cfg_we, cfg_idx, cfg_outchannel, cfg_kernel, cfg_flen, cfg_nconv,
    output num_layers, start, acc,
    input  busy, done, layer_idx, core_clear, core_enable,
    input  num_outchannel, num_kernel, filter_length, num_total_conv, err
  );

  modport slave (
`ifdef LAYER_PERF_EN
    output last_layer_cycles,
`endif
    input  cfg_we, cfg_idx, cfg_outchannel, cfg_kernel, cfg_flen, cfg_nconv,
    input  num_layers, start, acc,
    output busy, done, layer_idx, core_clear, core_enable,
    output num_outchannel, num_kernel, filter_length, num_total_conv, err
  );

endinterface

// File: rtl/layer_cfg_table.sv
// Register file of per-layer convolution configurations: one synchronous
// write port, one combinational read port, cleared by asynchronous reset.
module layer_cfg_table
  import conv_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [LIDX_WIDTH-1:0] wr_idx,
  input  layer_cfg_t            wr_data,
  input  logic [LIDX_WIDTH-1:0] rd_idx,
  output layer_cfg_t            rd_data
);

  layer_cfg_t entries [MAX_LAYERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        entries[i] <= '0;
      end
    end else if (we) begin
      entries[wr_idx] <= wr_data;
    end
  end

  assign rd_data = entries[rd_idx];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Steps conv_core through a table of layer configurations, counting acc
// pulses per layer and draining between layers. Optional: LAYER_PERF_EN.
module conv_layer_sequencer
  import conv_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  conv_layer_sequencer_if.slave bus
);

  localparam logic [LIDX_WIDTH:0]      MAX_LAYERS_L = (LIDX_WIDTH+1)'(MAX_LAYERS);
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

  seq_state_t                  state, state_next;
  layer_cfg_t                  cfg_r, rd_cfg, wr_cfg;
  logic [LIDX_WIDTH:0]         run_layers, clamped_layers;
  logic [LIDX_WIDTH-1:0]       layer_idx_r, rd_idx;
  logic [TIMESTEP_WIDTH-1:0]   acc_cnt;
  logic [DRAIN_CNT_WIDTH-1:0]  drain_cnt;
  logic                        err_r, err_set, busy_int, start_accept;
  logic                        over_layers, last_acc, last_layer, load_cfg;

  assign wr_cfg = '{outchannel: bus.cfg_outchannel, kernel: bus.cfg_kernel,
                    flen: bus.cfg_flen, nconv: bus.cfg_nconv};

  layer_cfg_table u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.cfg_we && !busy_int),
    .wr_idx  (bus.cfg_idx),
    .wr_data (wr_cfg),
    .rd_idx  (rd_idx),
    .rd_data (rd_cfg)
  );

  assign busy_int       = (state != IDLE);
  assign start_accept   = (state == IDLE) && bus.start;
  assign over_layers    = (bus.num_layers > MAX_LAYERS_L);
  assign clamped_layers = over_layers ? MAX_LAYERS_L : bus.num_layers;
  assign last_acc       = bus.acc && (TIMESTEP_WIDTH'(acc_cnt + 1'b1) == cfg_r.nconv);
  assign last_layer     = ({1'b0, layer_idx_r} == (run_layers - 1'b1));
  assign err_set        = (bus.acc && (state != RUN)) || (bus.cfg_we && busy_int) ||
                          (start_accept && over_layers);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Config registers are loaded on the transition into SETUP so SETUP already shows them.
  always_comb begin
    state_next = state;
    load_cfg   = 1'b0;
    rd_idx     = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (clamped_layers == '0) begin
            state_next = FINISH;
          end else begin
            state_next = SETUP;
            load_cfg   = 1'b1;
          end
        end
      end
      SETUP:  state_next = (cfg_r.nconv == '0) ? DRAIN : RUN;
      RUN:    if (last_acc) state_next = DRAIN;
      DRAIN:  if (drain_cnt == DRAIN_LAST) state_next = NEXT;
      NEXT: begin
        if (last_layer) begin
          state_next = FINISH;
        end else begin
          state_next = SETUP;
          load_cfg   = 1'b1;
          rd_idx     = layer_idx_r + 1'b1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_r       <= '0;
      run_layers  <= '0;
      layer_idx_r <= '0;
      acc_cnt     <= '0;
      drain_cnt   <= '0;
      err_r       <= 1'b0;
    end else begin
      if (load_cfg) cfg_r <= rd_cfg;
      if (start_accept) begin
        run_layers  <= clamped_layers;
        layer_idx_r <= '0;
      end else if (state == NEXT && !last_layer) begin
        layer_idx_r <= layer_idx_r + 1'b1;
      end
      if (state == SETUP) begin
        acc_cnt <= '0;
      end else if (state == RUN && bus.acc) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      // A new run wipes older errors but can still flag its own start condition.
      if (start_accept) begin
        err_r <= err_set;
      end else if (err_set) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef LAYER_PERF_EN
  logic [PERF_WIDTH-1:0] run_cycles, last_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cycles  <= '0;
      last_cycles <= '0;
    end else begin
      if (state == SETUP) begin
        run_cycles <= '0;
      end else if (state == RUN && run_cycles != '1) begin
        run_cycles <= run_cycles + 1'b1;
      end
      if (state == SETUP && state_next == DRAIN) begin
        last_cycles <= '0;
      end else if (state == RUN && state_next == DRAIN) begin
        last_cycles <= (run_cycles == '1) ? run_cycles : run_cycles + 1'b1;
      end
    end
  end

  assign bus.last_layer_cycles = last_cycles;
`endif

  assign bus.busy           = busy_int;
  assign bus.done           = (state == FINISH);
  assign bus.core_clear     = (state == SETUP);
  assign bus.core_enable    = (state == RUN);
  assign bus.layer_idx      = layer_idx_r;
  assign bus.num_outchannel = cfg_r.outchannel;
  assign bus.num_kernel     = cfg_r.kernel;
  assign bus.filter_length  = cfg_r.flen;
  assign bus.num_total_conv = cfg_r.nconv;
  assign bus.err            = err_r;

endmodule
